// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: funct3 encodings, memory-stage FSM states
// and the branch-condition decode.
package riscv_pkg;

  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;

  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Signedness was already folded into the comparator flags by execution.
  function automatic logic branch_cond(input logic [2:0] f3, input logic eq, input logic lt);
    logic c;
    c = 1'b0;
    case (f3)
      F3_BEQ:           c = eq;
      F3_BNE:           c = !eq;
      F3_BLT, F3_BLTU:  c = lt;
      F3_BGE, F3_BGEU:  c = !lt;
      default:          c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the memory stage: store byte enables and lane
// replication, alignment check, and load byte/half extraction with extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic        mem_op,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  output logic        misaligned,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store lanes, byte enables and alignment share the size field funct3[1:0].
  always_comb begin
    st_be      = 4'b0000;
    st_lanes   = st_data;
    misaligned = 1'b0;
    case (st_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr_lo;
        st_lanes = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_be      = 4'b0011 << {addr_lo[1], 1'b0};
        st_lanes   = {2{st_data[15:0]}};
        misaligned = mem_op & addr_lo[0];
      end
      2'b10: begin
        st_be      = 4'b1111;
        misaligned = mem_op & (addr_lo != 2'b00);
      end
      default: st_be = 4'b0000;
    endcase
  end

  assign byte_s = ld_word[{ld_offset, 3'b000} +: 8];
  assign half_s = ld_offset[1] ? ld_word[31:16] : ld_word[15:0];

  // Load extraction and sign/zero extension.
  always_comb begin
    ld_data = ld_word;
    case (ld_funct3)
      F3_LB:   ld_data = {{24{byte_s[7]}}, byte_s};
      F3_LH:   ld_data = {{16{half_s[15]}}, half_s};
      F3_LW:   ld_data = ld_word;
      F3_LBU:  ld_data = {24'h00_0000, byte_s};
      F3_LHU:  ld_data = {16'h0000, half_s};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage: resolves branches back to fetch, runs loads/stores over a
// req/ack data bus with a watchdog, and registers write-back/forward data.
module memory_access
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result_from_execution,
  input  logic [31:0] rs2_data_from_execution,
  input  logic [31:0] branch_addr_from_execution,
  input  logic [2:0]  funct3_from_execution,
  input  logic [4:0]  rd_from_execution,
  input  logic        write_reg_from_execution,
  input  logic        select_from_execution,
  input  logic        read_from_execution,
  input  logic        write_from_execution,
  input  logic        branch_from_execution,
  input  logic        u_branch_from_execution,
  input  logic        equal_from_execution,
  input  logic        greater_from_execution,
  input  logic        lesser_from_execution,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_from_memory,
  output logic [31:0] next_pc,
  output logic        load_next_pc,
  output logic [31:0] result_from_memory,
  output logic [4:0]  rd_from_memory,
  output logic        write_reg_from_memory,
  output logic        misaligned_from_memory,
  output logic        bus_error_from_memory
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t  state_r, next_state_s;
  logic [7:0]  wd_cnt_r;
  logic [2:0]  ld_funct3_r;
  logic [1:0]  ld_offset_r;
  logic        ld_read_r, ld_wr_r;
  logic [4:0]  ld_rd_r;
  logic        mem_op_s, misaligned_s, taken_s, timeout_s, stall_s;
  logic [3:0]  st_be_s;
  logic [31:0] st_lanes_s, ld_data_s;
  logic        unused_s;

  // Comparator "greater" and the select bit carry no information this stage needs.
  assign unused_s  = greater_from_execution ^ select_from_execution;
  assign mem_op_s  = read_from_execution | write_from_execution;
  assign taken_s   = u_branch_from_execution |
                     (branch_from_execution &
                      branch_cond(funct3_from_execution, equal_from_execution, lesser_from_execution));
  assign timeout_s = (state_r == BUSY) && (wd_cnt_r == TIMEOUT_LAST);

  lsu_align u_lsu_align (
    .mem_op     (mem_op_s),
    .st_funct3  (funct3_from_execution),
    .addr_lo    (result_from_execution[1:0]),
    .st_data    (rs2_data_from_execution),
    .st_be      (st_be_s),
    .st_lanes   (st_lanes_s),
    .misaligned (misaligned_s),
    .ld_funct3  (ld_funct3_r),
    .ld_offset  (ld_offset_r),
    .ld_word    (dmem_rdata),
    .ld_data    (ld_data_s)
  );

  // Stall and next-state decode; ack takes priority over the watchdog.
  always_comb begin
    stall_s      = 1'b0;
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        stall_s = mem_op_s & !misaligned_s;
        if (stall_s) next_state_s = BUSY;
        else         next_state_s = IDLE;
      end
      BUSY: begin
        stall_s = !dmem_ack & !timeout_s;
        if (dmem_ack || timeout_s) next_state_s = IDLE;
        else                       next_state_s = BUSY;
      end
      default: begin
        stall_s      = 1'b0;
        next_state_s = IDLE;
      end
    endcase
  end

  assign stall_from_memory = stall_s;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= next_state_s;
  end

  // Bus, op latch, watchdog and output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req               <= 1'b0;
      dmem_we                <= 1'b0;
      dmem_addr              <= 32'h0000_0000;
      dmem_wdata             <= 32'h0000_0000;
      dmem_be                <= 4'b0000;
      wd_cnt_r               <= 8'h00;
      ld_funct3_r            <= 3'b000;
      ld_offset_r            <= 2'b00;
      ld_read_r              <= 1'b0;
      ld_wr_r                <= 1'b0;
      ld_rd_r                <= 5'd0;
      next_pc                <= 32'h0000_0000;
      load_next_pc           <= 1'b0;
      result_from_memory     <= 32'h0000_0000;
      rd_from_memory         <= 5'd0;
      write_reg_from_memory  <= 1'b0;
      misaligned_from_memory <= 1'b0;
      bus_error_from_memory  <= 1'b0;
    end else begin
      load_next_pc           <= 1'b0;
      write_reg_from_memory  <= 1'b0;
      misaligned_from_memory <= 1'b0;
      bus_error_from_memory  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (mem_op_s && !misaligned_s) begin
            dmem_req    <= 1'b1;
            dmem_we     <= write_from_execution;
            dmem_addr   <= {result_from_execution[31:2], 2'b00};
            dmem_be     <= st_be_s;
            dmem_wdata  <= st_lanes_s;
            wd_cnt_r    <= 8'h00;
            ld_funct3_r <= funct3_from_execution;
            ld_offset_r <= result_from_execution[1:0];
            ld_read_r   <= read_from_execution;
            ld_wr_r     <= write_reg_from_execution;
            ld_rd_r     <= rd_from_execution;
          end else begin
            result_from_memory     <= result_from_execution;
            rd_from_memory         <= rd_from_execution;
            write_reg_from_memory  <= write_reg_from_execution & !misaligned_s;
            misaligned_from_memory <= misaligned_s;
            if (taken_s && !mem_op_s) begin
              next_pc      <= branch_addr_from_execution;
              load_next_pc <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (ld_read_r) begin
              result_from_memory    <= ld_data_s;
              rd_from_memory        <= ld_rd_r;
              write_reg_from_memory <= ld_wr_r;
            end
          end else if (timeout_s) begin
            dmem_req              <= 1'b0;
            dmem_we               <= 1'b0;
            bus_error_from_memory <= 1'b1;
          end else begin
            wd_cnt_r <= wd_cnt_r + 8'h01;
          end
        end
        default: dmem_req <= 1'b0;
      endcase
    end
  end

endmodule
